// File: rtl/nes_bus.sv
// NES CPU bus decoder: 2 KB mirrored RAM, PRG ROM, open bus and controller shift registers; reads land in d_out one cycle after sampling.
// Defining NES_BUS_PAD2_EN adds a second controller port at $4017 fed by btn2.
module nes_bus (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic [7:0]  btn1,
  input  logic [7:0]  btn2
);

  logic [7:0] ram [0:2047];
  logic       strobe;
  logic [7:0] sr1;
  logic       sel_ram;
  logic       sel_pad1;
  logic       sel_rom;
  logic       reload;
  logic       pad1_bit;

  assign rom_addr = addr[14:0];

  always_comb begin
    sel_ram  = (addr[15:13] == 3'b000);
    sel_pad1 = (addr == 16'h4016);
    sel_rom  = addr[15];
    // Old strobe high keeps the shifters tracking the live buttons.
    reload   = strobe | (we & sel_pad1 & d_in[0]);
    pad1_bit = strobe ? btn1[0] : sr1[0];
  end

`ifdef NES_BUS_PAD2_EN
  logic       sel_pad2;
  logic [7:0] sr2;
  logic       pad2_bit;

  always_comb begin
    sel_pad2 = (addr == 16'h4017);
    pad2_bit = strobe ? btn2[0] : sr2[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr2 <= 8'hFF;
    end else if (reload) begin
      sr2 <= btn2;
    end else if (!we && sel_pad2) begin
      sr2 <= {1'b1, sr2[7:1]};
    end
  end
`else
  logic unused_btn2;
  assign unused_btn2 = ^btn2;
`endif

  // RAM is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (we && sel_ram) begin
      ram[addr[10:0]] <= d_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out  <= 8'h00;
      strobe <= 1'b0;
      sr1    <= 8'hFF;
    end else begin
      if (we && sel_pad1) begin
        strobe <= d_in[0];
      end

      if (reload) begin
        sr1 <= btn1;
      end else if (!we && sel_pad1) begin
        sr1 <= {1'b1, sr1[7:1]};
      end

      // Unmapped reads fall through and leave d_out holding the last bus value.
      if (we) begin
        d_out <= d_in;
      end else if (sel_ram) begin
        d_out <= ram[addr[10:0]];
      end else if (sel_rom) begin
        d_out <= rom_data;
      end else if (sel_pad1) begin
        d_out <= {7'b0100000, pad1_bit};
`ifdef NES_BUS_PAD2_EN
      end else if (sel_pad2) begin
        d_out <= {7'b0100000, pad2_bit};
`endif
      end
    end
  end

endmodule

// File: tb/tb_nes_bus.sv
// Scoreboard bench for nes_bus: expected d_out values are queued as each cycle is driven and checked after the edge.
module tb_nes_bus;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  btn1;
  logic [7:0]  btn2;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] ram_model [0:2047];
  logic [7:0] wr_seen [0:2047];

  nes_bus dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .we       (we),
    .d_in     (d_in),
    .d_out    (d_out),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .btn1     (btn1),
    .btn2     (btn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
    addr = a;
    we   = w;
    d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pop(input string name);
    logic [7:0] e;
    e = exp_q.pop_front();
    total++;
    if (d_out !== e) begin
      bad++;
      $display("FAIL %s: d_out=%h expected=%h", name, d_out, e);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string name);
    exp_q.push_back(e);
    bus(a, 1'b0, 8'h00);
    chk_pop(name);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input string name);
    exp_q.push_back(d);
    bus(a, 1'b1, d);
    chk_pop(name);
  endtask

  task automatic test_reset;
    rst = 1'b1; addr = 16'h0000; we = 1'b0; d_in = 8'h00;
    rom_data = 8'h00; btn1 = 8'h00; btn2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (d_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_dout: d_out=%h expected=00", d_out);
    end
    rst = 1'b0;
    rd(16'h4016, 8'h41, "reset_sr1_ff");
  endtask

  task automatic test_ram;
    wr(16'h0005, 8'h5A, "ram_wr");
    rd(16'h0805, 8'h5A, "ram_mirror_0805");
    rd(16'h1805, 8'h5A, "ram_mirror_1805");
    for (int i = 0; i < 4; i++) begin
      wr(16'h0100 + 16'(i), 8'hA0 + 8'(i), "ram_wr_loop");
    end
    for (int i = 0; i < 4; i++) begin
      rd(16'h1100 + 16'(i), 8'hA0 + 8'(i), "ram_rd_loop");
    end
  endtask

  task automatic test_rom;
    rom_data = 8'hC3;
    addr = 16'hFFFC; we = 1'b0;
    #1;
    total++;
    if (rom_addr !== 15'h7FFC) begin
      bad++;
      $display("FAIL rom_addr: rom_addr=%h expected=7ffc", rom_addr);
    end
    rd(16'hFFFC, 8'hC3, "rom_read");
    wr(16'h8000, 8'h99, "rom_write_dout");
    rom_data = 8'h3C;
    rd(16'h8123, 8'h3C, "rom_read2");
  endtask

  task automatic test_open_bus;
    wr(16'h2000, 8'h77, "open_wr");
    rd(16'h2002, 8'h77, "open_2002");
    rd(16'h5000, 8'h77, "open_5000");
  endtask

  task automatic test_pad1;
    logic [7:0] seq [9];
    seq = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    btn1 = 8'h81;
    wr(16'h4016, 8'h01, "pad1_strobe_hi");
    wr(16'h4016, 8'h00, "pad1_strobe_lo");
    btn1 = 8'h00;
    for (int i = 0; i < 9; i++) begin
      rd(16'h4016, seq[i], "pad1_shift");
    end
  endtask

  task automatic test_strobe_live;
    wr(16'h4016, 8'hFF, "live_strobe_hi");
    for (int i = 0; i < 6; i++) begin
      btn1 = (i % 2 == 0) ? 8'hFE : 8'h01;
      rd(16'h4016, 8'h40 | {7'b0, btn1[0]}, "live_track");
    end
    btn1 = 8'h00;
    wr(16'h4016, 8'h00, "live_strobe_lo");
    btn1 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      rd(16'h4016, 8'h40, "live_shift");
    end
    rst = 1'b1;
    #1;
    total++;
    if (d_out !== 8'h00) begin
      bad++;
      $display("FAIL midreset_dout: d_out=%h expected=00", d_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    btn1 = 8'h00;
    rd(16'h4016, 8'h41, "midreset_abort");
    rd(16'h0805, 8'h5A, "ram_kept_over_rst");
  endtask

  task automatic test_pad2;
`ifdef NES_BUS_PAD2_EN
    btn2 = 8'h02;
    btn1 = 8'h00;
    wr(16'h4016, 8'h01, "pad2_strobe_hi");
    wr(16'h4016, 8'h00, "pad2_strobe_lo");
    btn2 = 8'h00;
    rd(16'h4017, 8'h40, "pad2_bit0");
    rd(16'h4017, 8'h41, "pad2_bit1");
    rd(16'h4017, 8'h40, "pad2_bit2");
    rd(16'h4016, 8'h40, "pad2_pad1_indep");
`else
    btn2 = 8'hFF;
    wr(16'h4017, 8'h12, "pad2_off_wr");
    rd(16'h4017, 8'h12, "pad2_off_open");
`endif
  endtask

  task automatic test_back_to_back;
    logic [10:0] a;
    logic [7:0]  d;
    for (int i = 0; i < 2048; i++) wr_seen[i] = 8'h00;
    for (int i = 0; i < 12; i++) begin
      a = 11'($urandom_range(0, 2047));
      d = 8'($urandom);
      ram_model[a] = d;
      wr_seen[a] = 8'h01;
      wr({3'($urandom_range(0, 3)), 2'b00, a} & 16'h1FFF, d, "b2b_wr");
      rd({3'b000, 2'($urandom_range(0, 3)), a}, ram_model[a], "b2b_rd");
    end
    btn1 = 8'h05;
    wr(16'h4016, 8'h01, "noshift_strobe_hi");
    wr(16'h4016, 8'h00, "noshift_strobe_lo");
    btn1 = 8'hFF;
    rd(16'h4016, 8'h41, "noshift_b0");
    wr(16'h0010, 8'h33, "noshift_ram_wr");
    rd(16'h0010, 8'h33, "noshift_ram_rd");
    rd(16'hC000, 8'h3C, "noshift_rom_rd");
    rd(16'h4016, 8'h40, "noshift_b1");
    rd(16'h4016, 8'h41, "noshift_b2");
  endtask

  initial begin
    test_reset();
    test_ram();
    test_rom();
    test_open_bus();
    test_pad1();
    test_strobe_live();
    test_pad2();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
